way3_reg: RTL

- Triplicated storage register: the producing end of a three-way vote, holding three replicas of one word.
- Replicas are voted every cycle; single-replica upsets are scrubbed (voted value written back to all three).
- Detected faults are reported as status and counters to the safety unit.
- Used for configuration and state registers that feed redundancy-checked logic.

---
 rtl/way3_reg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/way3_reg.sv
`default_nettype none
// ============================================================================
//  Module      : way3_reg
//  Description : Triplicated storage register. Three replicas of one word are
//                voted every cycle. A single-replica upset is scrubbed by
//                writing the voted word back to all three replicas. Three
//                pairwise-distinct replicas put the block into FAULT until a
//                write or a clear. Scrubs are reported as a one-cycle pulse
//                and counted in a saturating counter.
//                Optional feature macro: WAY3_REG_INJ_EN adds the
//                fault-injection ports inj_en_i / inj_sel_i / inj_mask_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module way3_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
`ifdef WAY3_REG_INJ_EN
    input  logic             inj_en_i,
    input  logic [1:0]       inj_sel_i,
    input  logic [WIDTH-1:0] inj_mask_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rep0_o,
    output logic [WIDTH-1:0] rep1_o,
    output logic [WIDTH-1:0] rep2_o,
    output logic             mismatch_o,
    output logic             corrected_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] corr_cnt_o
);

    typedef enum logic [0:0] {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_rep0;
    logic [WIDTH-1:0] r_rep1;
    logic [WIDTH-1:0] r_rep2;
    state_t           r_state;
    logic             r_corrected;
    logic [CNT_W-1:0] r_cnt;

    logic             w_eq01;
    logic             w_eq02;
    logic             w_eq12;
    logic             w_single;
    logic             w_dual;
    logic [WIDTH-1:0] w_vote;
    logic             w_inj;
    logic             w_scrub;

    // Word-level vote: replica 0 wins whenever it agrees with anyone, and
    // also when nobody agrees (no majority to prefer).
    always_comb begin
        w_eq01   = (r_rep0 == r_rep1);
        w_eq02   = (r_rep0 == r_rep2);
        w_eq12   = (r_rep1 == r_rep2);
        w_dual   = !w_eq01 && !w_eq02 && !w_eq12;
        w_single = !(w_eq01 && w_eq02) && !w_dual;
        if (w_eq01 || w_eq02) begin
            w_vote = r_rep0;
        end else if (w_eq12) begin
            w_vote = r_rep1;
        end else begin
            w_vote = r_rep0;
        end
    end

`ifdef WAY3_REG_INJ_EN
    // Injection is active only when no write is pending and a real replica
    // is selected; selector value 3 is a no-op.
    assign w_inj = inj_en_i && !wr_en_i && (inj_sel_i != 2'd3);
`else
    assign w_inj = 1'b0;
`endif

    // Scrub only from OK, and only when nothing else is rewriting replicas.
    assign w_scrub = (r_state == ST_OK) && w_single && !wr_en_i && !w_inj;

    // Replica storage: write beats injection beats scrub beats hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rep0 <= RST_VAL;
            r_rep1 <= RST_VAL;
            r_rep2 <= RST_VAL;
        end else if (wr_en_i) begin
            r_rep0 <= data_i;
            r_rep1 <= data_i;
            r_rep2 <= data_i;
`ifdef WAY3_REG_INJ_EN
        end else if (w_inj) begin
            if (inj_sel_i == 2'd0) r_rep0 <= r_rep0 ^ inj_mask_i;
            if (inj_sel_i == 2'd1) r_rep1 <= r_rep1 ^ inj_mask_i;
            if (inj_sel_i == 2'd2) r_rep2 <= r_rep2 ^ inj_mask_i;
`endif
        end else if (w_scrub) begin
            r_rep0 <= w_vote;
            r_rep1 <= w_vote;
            r_rep2 <= w_vote;
        end
    end

    // Health FSM: a dual mismatch in OK latches FAULT; write or clear leaves
    // it. After a clear the FSM re-checks the replicas on the next edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_OK;
        end else if (wr_en_i) begin
            r_state <= ST_OK;
        end else begin
            case (r_state)
                ST_OK: begin
                    if (w_dual && !w_inj) begin
                        r_state <= ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (clear_i) begin
                        r_state <= ST_OK;
                    end
                end
                default: r_state <= ST_OK;
            endcase
        end
    end

    // One-cycle pulse following each scrub edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_corrected <= 1'b0;
        end else begin
            r_corrected <= w_scrub;
        end
    end

    // Saturating scrub counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_scrub && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

    assign q_o         = w_vote;
    assign rep0_o      = r_rep0;
    assign rep1_o      = r_rep1;
    assign rep2_o      = r_rep2;
    assign mismatch_o  = w_single || w_dual;
    assign corrected_o = r_corrected;
    assign fault_o     = (r_state == ST_FAULT);
    assign corr_cnt_o  = r_cnt;

endmodule
`default_nettype wire
